// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel tick/clock-enable generator.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned DIV_RST_DEF = 5_000_000;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, tick and toggling output.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RST_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             clk_out,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] sdiv;
    logic             terminal_c;

    // Last count of the period; a halted (div==0) channel never gets here.
    assign terminal_c = en && (div != '0) && (cnt == div - CNT_W'(1));

    // Counter, divisor hand-over and registered outputs; sync beats everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div     <= DIV_RST;
            sdiv    <= DIV_RST;
            pend    <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (wr) begin
                sdiv <= wr_div;
            end
            if (sync) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                pend    <= 1'b0;
                if (wr) begin
                    div <= wr_div;
                end else if (pend) begin
                    div <= sdiv;
                end
            end else if (div == '0) begin
                // Halted: take any pending divisor straight away; a fresh write pends for next cycle.
                cnt  <= '0;
                pend <= wr;
                if (pend) begin
                    div <= sdiv;
                end
            end else if (terminal_c) begin
                cnt     <= '0;
                tick    <= 1'b1;
                clk_out <= ~clk_out;
                pend    <= 1'b0;
                if (wr) begin
                    div <= wr_div;
                end else if (pend) begin
                    div <= sdiv;
                end
            end else begin
                if (en) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (wr) begin
                    pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent programmable dividers with a shared divisor write port and phase-align.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned      N_CH    = 4,
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RST_DEF),
    localparam int unsigned     CH_W    = ch_idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  pend
);

    // Per-channel instances; an out-of-range wr_ch matches no channel and is dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_hit;

        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr_hit),
            .wr_div  (wr_div),
            .tick    (tick[i]),
            .clk_out (clk_out[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel tick and clock-enable generator, successor to the team's fixed single-output 100 ms divider. Each of N_CH channels divides the system clock by a run-time programmable divisor and produces a one-cycle tick plus a 50%-style toggling output. It feeds the display-refresh, debounce and rev-counter gate timing in the same design. Divisor changes are glitch-free: applied at the next terminal count.

## Interface
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 32, counter and divisor width
- DIV_RST, 5_000_000, divisor loaded into every channel at reset
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  N_CH  per-channel count enable
- sync  in  1  synchronous phase-align: restart all channels
- wr_en  in  1  divisor write strobe
- wr_ch  in  $clog2(N_CH) (min 1)  channel index for write
- wr_div  in  CNT_W  new divisor value
- tick  out  N_CH  one-cycle pulse per divide period
- clk_out  out  N_CH  toggles on every tick
- pend  out  N_CH  shadow divisor written, not yet applied

## Operation
- Per channel: counter cnt, active divisor div, shadow sdiv, pend flag.
- Reset (rst_n low, async): cnt=0, div=sdiv=DIV_RST, pend=0, tick=0, clk_out=0.
- en[i]=1, div≥1: cnt increments; when cnt==div-1 (terminal) → cnt=0, tick[i]=1 next cycle, clk_out[i] toggles same edge.
- div=1: tick every enabled cycle; clk_out toggles every cycle.
- div=0: channel halted; cnt held at 0, no ticks, clk_out holds.
- en[i]=0: cnt, clk_out hold; tick=0. Re-enable resumes from held count.
- Write (wr_en, wr_ch=i): sdiv=wr_div, pend=1. wr_ch≥N_CH ignored.
- Apply: at terminal, if pend → div=sdiv, pend=0. If div==0 → applied next cycle immediately (halted channel cannot reach terminal), cnt=0.
- Write coincident with terminal on same channel: wr_div applied at that terminal (bypass); pend stays 0.
- sync: all channels cnt=0, clk_out=0, tick=0; pending shadows applied. sync overrides terminal in same cycle (no tick) and overrides en=0.
- Counter arithmetic CNT_W bits unsigned; no overflow possible since cnt<div.

## Timing
- tick and clk_out are registered; no combinational path input→output.
- en held high from first edge after reset release: tick[i] high in the cycle after edge k·div (k=1,2,…); clk_out period 2·div cycles.
- Write→pend visible: 1 cycle. Write to halted channel → first tick div cycles after apply.
- sync: outputs low one cycle after sync edge; first tick div cycles after sync deasserts.
- rst_n assertion mid-period: all outputs to reset value immediately, no partial tick.

## Structure
- Package clk_div_pkg: CNT_W default, DIV_RST default, channel-index width function.
- Sub-module clk_div_chan (one channel: cnt, div, sdiv, pend, tick, clk_out); top generates N_CH instances and decodes wr_ch.

## Test plan
- Reset, DIV_RST=4, en=all 1 → tick every 4 cycles on all channels, clk_out period 8, pend=0.
- Write ch1 div=3 mid-period (cnt=1) → pend[1]=1; old period 4 completes, then ticks every 3; pend clears at terminal.
- Write ch2 div=0 → ch2 halts after current terminal; later write div=2 → ticks resume every 2 cycles, first tick 2 cycles after apply.
- en[0] low for 5 cycles at cnt=2 → tick[0] suppressed, resumes with terminal 1 enabled cycle later; clk_out[0] held.
- sync pulse coinciding with ch0 terminal → no tick that cycle, all clk_out=0, all channels next tick exactly div cycles later, aligned.
- rst_n low mid-period with pend set → all outputs 0, div back to DIV_RST, pend=0; wr_ch=N_CH write ignored.
